// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares the single UART TX FIFO write port between NUM_REQ byte-stream
// sources. Ownership is handed out round-robin per message: once granted, a
// source keeps the FIFO until its last byte is written, so messages never
// interleave on the serial line. A watchdog frees the port if the owner goes
// silent mid-message while the FIFO still has room.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int STALL_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      tx_full,
  output logic                      wr_uart,
  output logic [DATA_W-1:0]         w_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic [7:0]                abort_cnt
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);

  // The release happens on the stall cycle that would bring the count to
  // STALL_CYCLES, so the register only ever needs to hold STALL_CYCLES-1.
  localparam logic [STALL_W-1:0] STALL_LAST  = STALL_W'(STALL_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_REQ - 1);
  localparam logic [7:0]         ABORT_MAX   = 8'hFF;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic                 busy_q;
  logic [IDX_W-1:0]     owner_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [STALL_W-1:0]   stall_q;
  logic [7:0]           abort_q;

  logic                 arb_found;
  logic [IDX_W-1:0]     owner_d;
  logic [IDX_W-1:0]     cand_idx;
  logic [IDX_W-1:0]     rr_ptr_d;
  logic                 sel_valid;
  logic                 sel_last;
  logic [DATA_W-1:0]    sel_data;
  logic                 xfer;
  logic                 stall_cycle;

  // Round-robin pick: first valid source scanning upward from rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    owner_d   = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!arb_found && req_valid[cand_idx]) begin
        arb_found = 1'b1;
        owner_d   = cand_idx;
      end
    end
  end

  // Route the owner's valid/last/data through the one-hot grant.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Transfer qualification, watchdog condition and pointer past the owner.
  always_comb begin
    xfer        = (state_q == XFER) && sel_valid && !tx_full;
    stall_cycle = (state_q == XFER) && !sel_valid && !tx_full;
    rr_ptr_d    = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
  end

  // Zero-latency path from the owning source to the FIFO write port.
  always_comb begin
    req_ready = '0;
    wr_uart   = xfer;
    w_data    = xfer ? sel_data : '0;
    if (state_q == XFER && !tx_full) begin
      req_ready = grant_q;
    end
  end

  // Arbitration FSM with its registered outputs, watchdog and abort counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      stall_q  <= '0;
      abort_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_found) begin
            state_q <= XFER;
            grant_q <= NUM_REQ'(1) << owner_d;
            busy_q  <= 1'b1;
            owner_q <= owner_d;
            stall_q <= '0;
          end
        end
        XFER: begin
          if (xfer) begin
            stall_q <= '0;
            if (sel_last) begin
              state_q  <= IDLE;
              grant_q  <= '0;
              busy_q   <= 1'b0;
              rr_ptr_q <= rr_ptr_d;
            end
          end else if (stall_cycle) begin
            if (stall_q == STALL_LAST) begin
              state_q  <= IDLE;
              grant_q  <= '0;
              busy_q   <= 1'b0;
              rr_ptr_q <= rr_ptr_d;
              stall_q  <= '0;
              if (abort_q != ABORT_MAX) begin
                abort_q <= abort_q + 8'd1;
              end
            end else begin
              stall_q <= stall_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign abort_cnt = abort_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit FIFO write port (wr_uart/w_data, back-pressured by tx_full) between NUM_REQ byte-stream message sources, e.g. the echo path, status reporter and debug dump.
- Arbitrates round-robin at message granularity: a granted source keeps the FIFO until it presents its last byte, so messages never interleave on UART_TX.
- A stall watchdog releases a source that stops sending mid-message.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 8: byte width, matches the UART FIFO.
- STALL_CYCLES, 1000: consecutive granted-but-invalid cycles before a forced release; must be ≥1.

Ports:
- clk  in  1: system clock (50 MHz).
- reset  in  1: synchronous, active-high reset.
- req_valid  in  NUM_REQ: source i has a byte on its data slice.
- req_data  in  NUM_REQ*DATA_W: source i byte on bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ: the byte on source i is the final byte of its message.
- req_ready  out  NUM_REQ: byte accepted from source i this cycle.
- tx_full  in  1: UART TX FIFO full.
- wr_uart  out  1: write strobe to the TX FIFO.
- w_data  out  DATA_W: byte to the TX FIFO.
- grant  out  NUM_REQ: one-hot owner, registered; all zero when idle.
- busy  out  1: a message is in progress (state XFER).
- abort_cnt  out  8: saturating count of watchdog releases.

Behaviour:
- Reset values: grant=0, busy=0, abort_cnt=0, rr_ptr=0, stall counter=0, state=IDLE. req_ready=0 and wr_uart=0 follow from state. w_data is 0 whenever wr_uart=0.
- Reset asserted mid-message drops the grant immediately, in the next cycle. The partial message already written to the FIFO is not recalled.
- IDLE state:
  - If any req_valid is set, pick the first index i scanning rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ.
  - Register grant=1<<i, go to XFER.
  - The arbitration decision costs 1 cycle; no byte is transferred in IDLE.
- XFER state, transfer condition: with g = granted index, xfer = req_valid[g] & ~tx_full.
- XFER state, combinational outputs:
  - req_ready[g] = ~tx_full. All other req_ready bits are 0.
  - wr_uart = xfer.
  - w_data = data slice g when xfer is true, else 0.
  - Zero latency from source to FIFO; at most one byte per cycle.
- XFER state, end of message: on xfer & req_last[g], next state is IDLE, grant=0, rr_ptr=(g+1) mod NUM_REQ. This guarantees the next owner differs from g whenever another source is valid.
- Back-to-back messages: a source holding valid continuously still gets 1 idle arbitration cycle between its messages.
- tx_full high: no write and no ready. The stall counter does not advance, because FIFO back-pressure is not a source stall.
- Stall watchdog:
  - The counter increments on each XFER cycle with ~req_valid[g] & ~tx_full.
  - It clears on any xfer and on entry to XFER.
  - When it reaches STALL_CYCLES: go to IDLE, grant=0, rr_ptr=(g+1) mod NUM_REQ, abort_cnt+1 (saturating at 255).
  - No byte is written in the release cycle.
- Valid changes outside grant are ignored. A non-granted source's valid/data/last may change freely and never produce ready.
- A single-byte message (valid & last on the first XFER cycle) occupies exactly 2 cycles: IDLE arbitration plus XFER.
- busy = (state==XFER), registered together with grant.

Test Plan:
- Single source: source 2 sends "OK\n" (0x4F,0x4B,0x0A; last on 0x0A), tx_full=0 -> grant=4'b0100 one cycle after valid; wr_uart high 3 consecutive cycles with w_data 0x4F,0x4B,0x0A; grant=0 the cycle after; rr_ptr=3.
- Fairness: sources 0 and 1 both continuously valid, each sending 2-byte messages -> FIFO byte order is 0,0,1,1,0,0,1,1 and messages never interleave; grant alternates 0001/0010.
- Back-pressure: tx_full held high for 5 cycles mid-message of source 3 -> wr_uart=0 and req_ready=0 for those 5 cycles; no byte lost or duplicated; abort_cnt stays 0.
- Stall: STALL_CYCLES=4, source 1 sends 1 non-last byte then drops valid -> release exactly 4 cycles after the last xfer; abort_cnt=1; a waiting source 2 is granted on the next arbitration.
- Wrap-around: rr_ptr=3 with NUM_REQ=4, sources 0 and 3 valid -> source 3 granted first, then source 0.
- Reset mid-message: reset asserted during byte 2 of 4 -> next cycle grant=0, wr_uart=0, abort_cnt=0; after release, normal arbitration resumes from rr_ptr=0.
